// File: rtl/sprite_drawer.sv
// CHIP-8 display engine: DXYN XOR sprite draw with collision and 00E0 clear.
// Owns the 64x32 framebuffer and provides a registered row-read port for the scanner.
module sprite_drawer (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         clear,
    input  logic [7:0]   x,
    input  logic [7:0]   y,
    input  logic [3:0]   n,
    input  logic [11:0]  i_addr,
    output logic         mem_rd_req,
    output logic [11:0]  mem_addr,
    output logic [3:0]   mem_read_len,
    input  logic [119:0] mem_data,
    output logic         busy,
    output logic         done,
    output logic         collision,
    input  logic [4:0]   fb_rd_row,
    output logic [63:0]  fb_rd_data
);

    typedef enum logic [2:0] {StIdle, StReq, StLatch, StDraw, StClear, StDone} state_e;

    state_e state_q, state_d;

    logic [5:0]   x0_q;
    logic [4:0]   y0_q;
    logic [3:0]   n_q;
    logic [119:0] buf_q;
    logic [4:0]   cnt_q;
    logic         acc_q;
    logic         coll_q;
    logic         op_draw_q;
    logic         mem_rd_req_q;
    logic [11:0]  mem_addr_q;
    logic [3:0]   mem_len_q;
    logic [63:0]  fb_q [32];
    logic [63:0]  fb_rd_data_q;

    logic [119:0] sprite_sh;
    logic [7:0]   sprite_byte;
    logic [7:0]   byte_rev;
    logic [63:0]  draw_mask;
    logic [63:0]  old_row;
    logic [5:0]   row_sum;
    logic         row_clip;
    logic [4:0]   row_idx;
    logic         unused_bits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (clear) begin
                    state_d = StClear;
                end else if (start) begin
                    state_d = (n == 4'd0) ? StDone : StReq;
                end
            end
            StReq:   state_d = StLatch;
            StLatch: state_d = StDraw;
            StDraw:  if (cnt_q[3:0] == n_q - 4'd1) state_d = StDone;
            StClear: if (cnt_q == 5'd31) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Row r lives in byte (n-1-r) of the buffer: the first fetched byte is the most significant.
    always_comb begin
        sprite_sh   = buf_q >> {n_q - 4'd1 - cnt_q[3:0], 3'b000};
        sprite_byte = sprite_sh[7:0];
        byte_rev    = '0;
        for (int k = 0; k < 8; k++) begin
            byte_rev[k] = sprite_byte[7-k];
        end
        // Bits shifted past column 63 fall off: no horizontal wrap.
        draw_mask = {56'd0, byte_rev} << x0_q;
        row_sum   = {1'b0, y0_q} + {2'b00, cnt_q[3:0]};
        row_clip  = row_sum[5];
        row_idx   = row_sum[4:0];
        old_row   = fb_q[row_idx];
    end

    assign unused_bits = ^{x[7:6], y[7:5], sprite_sh[119:8]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x0_q      <= '0;
            y0_q      <= '0;
            n_q       <= '0;
            buf_q     <= '0;
            cnt_q     <= '0;
            acc_q     <= 1'b0;
            coll_q    <= 1'b0;
            op_draw_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (clear) begin
                        cnt_q     <= '0;
                        op_draw_q <= 1'b0;
                    end else if (start) begin
                        x0_q      <= x[5:0];
                        y0_q      <= y[4:0];
                        n_q       <= n;
                        op_draw_q <= 1'b1;
                        acc_q     <= 1'b0;
                    end
                end
                StLatch: begin
                    buf_q <= mem_data;
                    acc_q <= 1'b0;
                    cnt_q <= '0;
                end
                StDraw: begin
                    cnt_q <= cnt_q + 5'd1;
                    if (!row_clip) acc_q <= acc_q | (|(old_row & draw_mask));
                end
                StClear: cnt_q <= cnt_q + 5'd1;
                StDone:  if (op_draw_q) coll_q <= acc_q;
                default: ;
            endcase
        end
    end

    // mmu request is only ever entered from IDLE, so the live operands are the latched ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rd_req_q <= 1'b0;
            mem_addr_q   <= '0;
            mem_len_q    <= '0;
        end else begin
            mem_rd_req_q <= (state_d == StReq);
            mem_addr_q   <= (state_d == StReq) ? i_addr : 12'd0;
            mem_len_q    <= (state_d == StReq) ? n : 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                fb_q[i] <= '0;
            end
        end else if (state_q == StDraw && !row_clip) begin
            fb_q[row_idx] <= old_row ^ draw_mask;
        end else if (state_q == StClear) begin
            fb_q[cnt_q] <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_rd_data_q <= '0;
        end else begin
            fb_rd_data_q <= fb_q[fb_rd_row];
        end
    end

    assign busy         = (state_q != StIdle);
    assign done         = (state_q == StDone);
    assign collision    = coll_q;
    assign mem_rd_req   = mem_rd_req_q;
    assign mem_addr     = mem_addr_q;
    assign mem_read_len = mem_len_q;
    assign fb_rd_data   = fb_rd_data_q;

endmodule

// File: tb/tb_sprite_drawer.sv
// Directed bench for sprite_drawer: pixel-level framebuffer model, readback scoreboard,
// latency, clipping, clear priority and mid-operation reset.
module tb_sprite_drawer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         clear;
    logic [7:0]   x;
    logic [7:0]   y;
    logic [3:0]   n;
    logic [11:0]  i_addr;
    logic         mem_rd_req;
    logic [11:0]  mem_addr;
    logic [3:0]   mem_read_len;
    logic [119:0] mem_data;
    logic         busy;
    logic         done;
    logic         collision;
    logic [4:0]   fb_rd_row;
    logic [63:0]  fb_rd_data;

    int errors = 0;
    int checks = 0;
    logic [63:0] model [32];
    logic        model_coll;
    logic [63:0] exp_q [$];

    sprite_drawer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .clear        (clear),
        .x            (x),
        .y            (y),
        .n            (n),
        .i_addr       (i_addr),
        .mem_rd_req   (mem_rd_req),
        .mem_addr     (mem_addr),
        .mem_read_len (mem_read_len),
        .mem_data     (mem_data),
        .busy         (busy),
        .done         (done),
        .collision    (collision),
        .fb_rd_row    (fb_rd_row),
        .fb_rd_data   (fb_rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear;
        for (int r = 0; r < 32; r++) model[r] = '0;
    endtask

    // Pixel-by-pixel reference of DXYN with wrap of the start point and clipping at the edges.
    task automatic model_draw(input int xx, input int yy, input int nn, input logic [119:0] data);
        int x0;
        int y0;
        int row;
        int col;
        logic [7:0] b;
        x0 = xx % 64;
        y0 = yy % 32;
        model_coll = 1'b0;
        for (int k = 0; k < nn; k++) begin
            b   = 8'(data >> (8 * (nn - 1 - k)));
            row = y0 + k;
            if (row < 32) begin
                for (int bi = 0; bi < 8; bi++) begin
                    col = x0 + bi;
                    if (col < 64 && b[7-bi]) begin
                        if (model[row][col]) model_coll = 1'b1;
                        model[row][col] = ~model[row][col];
                    end
                end
            end
        end
    endtask

    task automatic readback(input string tag);
        for (int r = 0; r < 32; r++) begin
            fb_rd_row = 5'(r);
            exp_q.push_back(model[r]);
            tick;
            check($sformatf("%s row%0d", tag, r), fb_rd_data, exp_q.pop_front());
        end
    endtask

    task automatic do_draw(input string tag, input int xx, input int yy, input int nn,
                           input logic [11:0] ia, input logic [119:0] data);
        int cyc;
        mem_data = data;
        x        = 8'(xx);
        y        = 8'(yy);
        n        = 4'(nn);
        i_addr   = ia;
        start    = 1'b1;
        model_draw(xx, yy, nn, data);
        tick;
        start  = 1'b0;
        // Operands must already be latched; scramble them.
        x      = 8'hA5;
        y      = 8'h5A;
        n      = 4'hF;
        i_addr = 12'hFFF;
        cyc    = 1;
        check({tag, " busy"}, 64'(busy), 64'd1);
        if (nn != 0) begin
            check({tag, " req"}, 64'(mem_rd_req), 64'd1);
            check({tag, " addr"}, 64'(mem_addr), 64'(ia));
            check({tag, " len"}, 64'(mem_read_len), 64'(nn));
            tick;
            cyc = 2;
            check({tag, " req_off"}, 64'({mem_rd_req, mem_addr, mem_read_len}), 64'd0);
        end
        while (!done && cyc < 100) begin
            tick;
            cyc++;
        end
        check({tag, " latency"}, 64'(cyc), (nn == 0) ? 64'd1 : 64'(nn + 3));
        tick;
        check({tag, " coll"}, 64'(collision), 64'(model_coll));
        check({tag, " idle"}, 64'({busy, done}), 64'd0);
    endtask

    initial begin
        int   cyc;
        logic coll_before;
        logic seen_done;

        rst_n     = 1'b0;
        start     = 1'b0;
        clear     = 1'b0;
        x         = '0;
        y         = '0;
        n         = '0;
        i_addr    = '0;
        mem_data  = '0;
        fb_rd_row = '0;
        model_clear();
        model_coll = 1'b0;
        #12;
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst coll", 64'(collision), 64'd0);
        check("rst mem", 64'({mem_rd_req, mem_addr, mem_read_len}), 64'd0);
        check("rst fbrd", fb_rd_data, 64'd0);
        tick;
        rst_n = 1'b1;
        tick;

        do_draw("glyph0", 0, 0, 5, 12'h050, 120'hF0909090F0);
        readback("glyph0");
        do_draw("glyph0_again", 0, 0, 5, 12'h050, 120'hF0909090F0);
        readback("erase");

        do_draw("corner", 62, 30, 4, 12'h300, 120'hFFFFFFFF);
        readback("corner");

        do_draw("wrap", 70, 40, 1, 12'h400, 120'h81);
        readback("wrap");

        do_draw("n0", 3, 3, 0, 12'h111, 120'hFF);
        readback("n0");

        for (int cx = 0; cx < 8; cx++) begin
            for (int ry = 0; ry < 3; ry++) begin
                do_draw($sformatf("fill%0d_%0d", cx, ry), cx * 8, ry * 15, 15, 12'h200, '1);
            end
        end
        readback("filled");

        coll_before = collision;
        n     = 4'd3;
        start = 1'b1;
        clear = 1'b1;
        tick;
        start = 1'b0;
        clear = 1'b0;
        cyc   = 1;
        check("clr req", 64'(mem_rd_req), 64'd0);
        while (!done && cyc < 100) begin
            start = (cyc == 10);
            tick;
            cyc++;
        end
        start = 1'b0;
        check("clr latency", 64'(cyc), 64'd33);
        model_clear();
        tick;
        check("clr no_queue", 64'(busy), 64'd0);
        check("clr coll", 64'(collision), 64'(coll_before));
        readback("cleared");

        do_draw("pre_rst", 20, 4, 3, 12'h222, 120'hC3C3C3);
        mem_data  = '1;
        x         = 8'd0;
        y         = 8'd0;
        n         = 4'd15;
        start     = 1'b1;
        seen_done = 1'b0;
        tick;
        start = 1'b0;
        cyc   = 1;
        while (cyc < 6) begin
            tick;
            cyc++;
            if (done) seen_done = 1'b1;
        end
        rst_n = 1'b0;
        #1;
        check("arst busy", 64'(busy), 64'd0);
        check("arst done", 64'({done, seen_done}), 64'd0);
        check("arst coll", 64'(collision), 64'd0);
        check("arst mem", 64'({mem_rd_req, mem_addr, mem_read_len}), 64'd0);
        check("arst fbrd", fb_rd_data, 64'd0);
        model_clear();
        tick;
        rst_n = 1'b1;
        readback("after_rst");
        do_draw("post_rst", 10, 5, 2, 12'h123, 120'h3CA5);
        readback("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sprite_drawer.md
# sprite_drawer

Executes the CHIP-8 display operations DXYN (XOR-draw sprite with collision) and 00E0 (clear screen) for the CPU. It owns the 64x32 monochrome framebuffer. Sprite bytes are fetched from the mmu through its multi-byte read path (rw_addr / read_len / data_out), and each row is XORed into the framebuffer one row per cycle. A registered row-read port feeds the display scanner.

## Interface
Parameters:
- none (screen fixed at 64x32; maximum sprite height 15 rows, matching the mmu's 15-byte read window)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  draw request, sampled in IDLE only
- clear  in  1  clear-screen request, sampled in IDLE only
- x  in  8  sprite column (VX value)
- y  in  8  sprite row (VY value)
- n  in  4  sprite height in rows (0..15)
- i_addr  in  12  sprite base address (I register)
- mem_rd_req  out  1  high while the drawer owns the mmu read address; the CPU muxes mem_addr/mem_read_len onto rw_addr/read_len and holds write_enable=0
- mem_addr  out  12  sprite address to mmu rw_addr
- mem_read_len  out  4  byte count to mmu read_len
- mem_data  in  120  mmu data_out
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when an operation completes
- collision  out  1  VF result of the last draw
- fb_rd_row  in  5  display read row
- fb_rd_data  out  64  framebuffer row; bit c = column c

## Operation
- States: IDLE, REQ, LATCH, DRAW, CLEAR, DONE.
- IDLE:
  - clear=1 goes to CLEAR. Clear wins if start and clear are both asserted in the same cycle.
  - start=1 with n≠0 goes to REQ.
  - start=1 with n=0 goes directly to DONE, with collision=0 and the framebuffer untouched.
- Start latch: on accepting start, latch x0=x[5:0], y0=y[4:0], n, and i_addr. Start coordinates wrap modulo 64/32.
- REQ (1 cycle):
  - mem_rd_req=1, mem_addr=latched I, mem_read_len=latched n.
  - The mmu registers data_out at the end of this cycle.
- LATCH (1 cycle): capture mem_data[119:0] into the internal sprite buffer, clear the collision accumulator, and set row counter r=0.
- DRAW (one row per cycle, r = 0..n-1):
  - Sprite byte for row r is buf[8*(n-r)-1 -: 8]. Row 0 is the most significant populated byte, per the mmu packing.
  - Target row is y0+r. If y0+r ≥ 32 the row is clipped: no write and no collision contribution.
  - Byte bit 7 maps to column x0, bit 0 to column x0+7. Columns ≥ 64 are clipped; there is no horizontal wrap.
  - New row = old row XOR the shifted/masked byte.
  - Collision accumulator |= any bit where old=1 and mask=1.
  - After r=n-1, go to DONE.
- CLEAR: one framebuffer row zeroed per cycle, rows 0..31 (32 cycles), then DONE. collision is unchanged.
- DONE (1 cycle): done=1, collision updated from the accumulator (draw only), then return to IDLE.
- collision holds its value until the next draw completes.
- start and clear asserted while busy are ignored; they are not queued.
- The sprite buffer, the latched operands, and the mmu read are insensitive to x/y/n/i_addr changes after acceptance.

## Timing
- Reset (async, rst_n=0): state=IDLE, entire framebuffer=0, busy=0, done=0, collision=0, mem_rd_req=0, mem_addr=0, mem_read_len=0, fb_rd_data=0.
- Reset asserted mid-operation aborts immediately. No done pulse is produced, and a partially drawn sprite is erased by the framebuffer reset.
- Draw latency: start sampled at edge 0.
  - REQ occupies cycle 1 and LATCH cycle 2.
  - DRAW occupies cycles 3..n+2.
  - done=1 in cycle n+3; busy=1 in cycles 1..n+3.
- n=0: done=1 in cycle 1.
- Clear: CLEAR occupies cycles 1..32, done=1 in cycle 33.
- mem_rd_req, mem_addr, and mem_read_len are registered. They are valid only in REQ and are 0 otherwise.
- fb_rd_data: registered, 1-cycle latency from fb_rd_row. In a cycle where that row is also being written, it returns the pre-write contents.

## Test plan
- Reset, then draw I=0x050, n=5, x=0, y=0 with mem_data[39:0]=F0_90_90_90_F0 ("0" glyph). Required: done in cycle 8. Row 0 bits [3:0]=1111, rows 1–3 bits 0 and 3 set, row 4 bits [3:0]=1111. collision=0.
- Repeat the identical draw → framebuffer returns to all-zero and collision=1.
- x=62, y=30, n=4, all bytes 0xFF → only columns 62/63 of rows 30/31 set. Clipped rows/columns produce no writes and collision=0.
- x=70, y=40 (wraps to 6, 8), n=1, byte 0x81 → row 8 columns 6 and 13 set.
- Fill the screen, assert start and clear in the same IDLE cycle → clear taken; done in cycle 33; all 32 rows read back 0; collision keeps its previous value; start asserted mid-clear ignored.
- Draw with n=15, then pull rst_n low at cycle 6 → all outputs 0 asynchronously, framebuffer 0, no done pulse. The next start behaves normally.
